// File: rtl/fetch_if.sv
// Bus bundle between the fetch sequencer and its pc block, ROM and decode stage.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface fetch_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 26
);
   logic [ADDR_W-1:0] pc_count;
   logic [INST_W-1:0] rom_data;
   logic              dec_ready;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              pc_en;
   logic [ADDR_W-1:0] new_pc;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] inst_out;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_valid;
   logic              halted;
   logic [15:0]       retired_cnt;

   modport master (
      input  pc_count, rom_data, dec_ready, branch_taken, branch_target,
      output pc_en, new_pc, rom_addr, inst_out, inst_pc, inst_valid, halted, retired_cnt
   );

   modport slave (
      output pc_count, rom_data, dec_ready, branch_taken, branch_target,
      input  pc_en, new_pc, rom_addr, inst_out, inst_pc, inst_valid, halted, retired_cnt
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: steps the pc, waits out ROM latency, holds the fetched
// instruction for decode, and handles branch redirects and the HALT opcode.
module fetch_sequencer #(
   parameter int          ADDR_W  = 16,
   parameter int          INST_W  = 26,
   parameter int          PC_STEP = 4,
   parameter int          ROM_LAT = 1,
   parameter logic [5:0]  HALT_OP = 6'h3F
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t            state_r;
   logic [2:0]        wait_cnt_r;
   logic [INST_W-1:0] inst_r;
   logic [ADDR_W-1:0] inst_pc_r;
   logic              valid_r;
   logic              halted_r;
   logic [15:0]       retired_r;
   logic [ADDR_W-1:0] new_pc_r;
   logic              pc_en_q_r;

   logic              branch_s;
   logic              accept_s;
   logic              pc_en_s;
   logic [ADDR_W-1:0] new_pc_s;

   // Redirect/accept decode; a branch right after a pc load is dropped so pc_en never repeats.
   always_comb begin
      branch_s = bus.branch_taken && !pc_en_q_r && (state_r != S_HALT) && !rst;
      accept_s = valid_r && bus.dec_ready;
      pc_en_s  = branch_s || accept_s;
      if (branch_s) begin
         new_pc_s = bus.branch_target;
      end else if (accept_s) begin
         new_pc_s = bus.pc_count + ADDR_W'(PC_STEP);
      end else begin
         new_pc_s = new_pc_r;
      end
   end

   // Fetch state machine with its held instruction and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= 3'd0;
         inst_r     <= '0;
         inst_pc_r  <= '0;
         valid_r    <= 1'b0;
         halted_r   <= 1'b0;
         retired_r  <= 16'd0;
         new_pc_r   <= '0;
         pc_en_q_r  <= 1'b0;
      end else begin
         pc_en_q_r <= pc_en_s;
         new_pc_r  <= new_pc_s;
         case (state_r)
            S_IDLE: begin
               state_r <= S_FETCH;
            end
            S_FETCH: begin
               if (branch_s) begin
                  state_r <= S_FETCH;
               end else begin
                  wait_cnt_r <= 3'(ROM_LAT);
                  state_r    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (branch_s) begin
                  state_r <= S_FETCH;
               end else if (wait_cnt_r == 3'd1) begin
                  inst_r    <= bus.rom_data;
                  inst_pc_r <= bus.pc_count;
                  valid_r   <= 1'b1;
                  state_r   <= S_HOLD;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 3'd1;
               end
            end
            S_HOLD: begin
               if (branch_s) begin
                  valid_r <= 1'b0;
                  state_r <= S_FETCH;
               end else if (accept_s) begin
                  valid_r   <= 1'b0;
                  retired_r <= retired_r + 16'd1;
                  if (inst_r[INST_W-1 -: 6] == HALT_OP) begin
                     halted_r <= 1'b1;
                     state_r  <= S_HALT;
                  end else begin
                     state_r  <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               halted_r <= 1'b1;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.pc_en       = pc_en_s;
   assign bus.new_pc      = new_pc_s;
   assign bus.rom_addr    = bus.pc_count;
   assign bus.inst_out    = inst_r;
   assign bus.inst_pc     = inst_pc_r;
   assign bus.inst_valid  = valid_r;
   assign bus.halted      = halted_r;
   assign bus.retired_cnt = retired_r;
endmodule
